mem_responder: RTL and testbench

- Word-granular backing-memory responder: the memory end of the cache-to-memory interface driven by the cache's o_mem_* port.
- Accepts one read or write at a time, holds off new requests with ready, and returns read data with a single-cycle valid pulse after a fixed latency.
- Used as the memory model under the instruction and data caches in simulation, and as the memory-side timing reference for the cache miss and write-through paths.

---
 rtl/mem_responder.sv | 98 +++++++++
 tb/tb_mem_responder.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Word-granular backing memory for the cache memory port: one request at a time,
// read data returned with a one-cycle valid pulse a fixed number of cycles after acceptance.
module mem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_mem_ready,
  input  logic [31:0] i_mem_addr,
  input  logic        i_mem_ren,
  input  logic        i_mem_wen,
  input  logic [31:0] i_mem_wdata,
  output logic [31:0] o_mem_rdata,
  output logic        o_mem_valid,
  output logic        o_err
);

  typedef enum logic [1:0] {IDLE, BUSY_RD, BUSY_WR} state_t;

  localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

  state_t            state, state_nxt;
  logic [7:0]        cnt, cnt_nxt;
  logic [31:0]       rd_word, rd_word_nxt;
  logic [31:0]       rdata_nxt;
  logic              valid_nxt, err_nxt;
  logic [31:0]       mem [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0] idx;
  logic              wr_accept;
  logic              unused_addr_bits;

  assign idx              = i_mem_addr[ADDR_W+1:2];
  assign unused_addr_bits = ^{i_mem_addr[31:ADDR_W+2], i_mem_addr[1:0]};
  assign o_mem_ready      = (state == IDLE);
  // An illegal ren&wen request is handled as a write, so wen alone decides the commit.
  assign wr_accept        = (state == IDLE) && i_mem_wen;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      cnt         <= 8'd0;
      rd_word     <= 32'd0;
      o_mem_rdata <= 32'd0;
      o_mem_valid <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      rd_word     <= rd_word_nxt;
      o_mem_rdata <= rdata_nxt;
      o_mem_valid <= valid_nxt;
      o_err       <= err_nxt;
    end
  end

  // Storage is deliberately not reset; a write commits at its accept edge.
  always_ff @(posedge i_clk) begin
    if (!i_rst && wr_accept) mem[idx] <= i_mem_wdata;
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    rd_word_nxt = rd_word;
    rdata_nxt   = o_mem_rdata;
    valid_nxt   = 1'b0;
    err_nxt     = o_err;
    case (state)
      IDLE: begin
        if (i_mem_wen) begin
          state_nxt = BUSY_WR;
          cnt_nxt   = CNT_LOAD;
          if (i_mem_ren) err_nxt = 1'b1;
        end else if (i_mem_ren) begin
          state_nxt   = BUSY_RD;
          cnt_nxt     = CNT_LOAD;
          rd_word_nxt = mem[idx];
        end
      end
      BUSY_RD: begin
        if (cnt == 8'd0) begin
          state_nxt = IDLE;
          rdata_nxt = rd_word;
          valid_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      BUSY_WR: begin
        if (cnt == 8'd0) state_nxt = IDLE;
        else             cnt_nxt   = cnt - 8'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: a driver issues requests and queues expected reads,
// a monitor pops and compares whenever valid pulses.
module tb_mem_responder;
  localparam int ADDR_W  = 10;
  localparam int LATENCY = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ready, valid, err;
  logic [31:0] addr = '0, wdata = '0, rdata;
  logic        ren = 1'b0, wen = 1'b0;

  typedef struct {logic [31:0] data; int cyc;} exp_t;
  exp_t        q[$];
  logic [31:0] mdl [0:(1<<ADDR_W)-1];
  bit          m_err = 1'b0;
  int          cyc = 0;
  int          vec = 0;
  int          bad = 0;

  mem_responder #(.ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
    .i_clk(clk), .i_rst(rst), .o_mem_ready(ready), .i_mem_addr(addr),
    .i_mem_ren(ren), .i_mem_wen(wen), .i_mem_wdata(wdata),
    .o_mem_rdata(rdata), .o_mem_valid(valid), .o_err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: any valid pulse must match the oldest queued read, in data and in cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && valid === 1'b1) begin
        if (q.size() == 0) begin
          vec++; bad++;
          $display("FAIL unexpected_valid: got valid=1 expected no pulse (cycle %0d)", cyc);
        end else begin
          e = q.pop_front();
          chk("rdata", rdata, e.data);
          chk("valid_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  // Drive one request, wait for acceptance, update the model; optionally check the busy window.
  task automatic issue(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d,
                       input bit intrude, input bit track);
    int t = 0;
    logic [ADDR_W-1:0] ix;
    ix = a[ADDR_W+1:2];
    @(negedge clk);
    ren = r; wen = w; addr = a; wdata = d;
    while (ready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    if (ready !== 1'b1) begin
      vec++; bad++;
      $display("FAIL ready_timeout: got ready=%b expected 1 within 50 cycles", ready);
      ren = 0; wen = 0;
      return;
    end
    @(posedge clk); #1;
    ren = 0; wen = 0;
    if (w) mdl[ix] = d;
    if (r && w) m_err = 1'b1;
    if (r && !w && track) q.push_back('{mdl[ix], cyc + LATENCY});
    if (!track) return;
    for (int k = 1; k <= LATENCY; k++) begin
      @(negedge clk);
      if (intrude && k == 1) begin wen = 1; addr = 32'h20; wdata = 32'h55; end
      if (intrude && k == 2) wen = 0;
      chk("ready_busy", {31'd0, ready}, 32'd0);
      chk("err", {31'd0, err}, {31'd0, m_err});
    end
  endtask

  initial begin
    logic [31:0] a;
    int op;
    #3 rst = 1;
    #1;
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    @(negedge clk); rst = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_ready", {31'd0, ready}, 32'd1);
    end

    for (int i = 0; i < 64; i++) issue(0, 1, 32'(i) << 2, $urandom(), 0, 1);

    issue(0, 1, 32'h10, 32'hDEADBEEF, 0, 1);
    issue(1, 0, 32'h10, 0, 0, 1);

    for (int i = 0; i < 4; i++) issue(0, 1, 32'(4 + i) << 2, 32'(8'h11 * (i + 1)), 0, 1);
    for (int i = 0; i < 4; i++) issue(1, 0, 32'(4 + i) << 2, 0, 0, 1);

    issue(1, 0, 32'h14, 0, 1, 1);
    issue(1, 0, 32'h20, 0, 0, 1);

    issue(1, 1, 32'h4, 32'h1234, 0, 1);
    issue(1, 0, 32'h4, 0, 0, 1);
    issue(0, 1, 32'h1004, 32'hAB, 0, 1);
    issue(1, 0, 32'h4, 0, 0, 1);
    chk("err_sticky", {31'd0, err}, 32'd1);

    issue(1, 0, 32'h10, 0, 0, 0);
    @(posedge clk); @(posedge clk); #2 rst = 1;
    #1;
    m_err = 1'b0;
    chk("midrst_ready", {31'd0, ready}, 32'd1);
    chk("midrst_valid", {31'd0, valid}, 32'd0);
    chk("midrst_rdata", rdata, 32'd0);
    chk("midrst_err", {31'd0, err}, 32'd0);
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
    chk("post_rst_ready", {31'd0, ready}, 32'd1);
    issue(1, 0, 32'h10, 0, 0, 1);

    for (int n = 0; n < 150; n++) begin
      a = $urandom();
      a[11:2] = 10'($urandom_range(0, 63));
      op = $urandom_range(0, 9);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      if (op == 0)      issue(1, 1, a, $urandom(), 0, 1);
      else if (op < 5)  issue(0, 1, a, $urandom(), 0, 1);
      else              issue(1, 0, a, 0, 0, 1);
    end

    repeat (LATENCY + 3) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    chk("final_err", {31'd0, err}, {31'd0, m_err});
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
